// File: rtl/int_ctrl_if.sv
// int_ctrl_if: bus bundle between the interrupt controller and its environment
// (device requests, config port, CPU interrupt/acknowledge handshake).
//   master : drives src_req, cfg_*, INTA_*; observes cfg_rdata, INT_*, *_id
//   slave  : the controller side (int_ctrl)
interface int_ctrl_if #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
);
    logic [NUM_SRC-1:0] src_req;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [NUM_SRC-1:0] cfg_wdata;
    logic [NUM_SRC-1:0] cfg_rdata;
    logic               INTA_irq;
    logic               INTA_fiq;
    logic               INT_irq;
    logic               INT_fiq;
    logic [ID_W-1:0]    irq_id;
    logic [ID_W-1:0]    fiq_id;

    modport master (
        output src_req, cfg_we, cfg_addr, cfg_wdata, INTA_irq, INTA_fiq,
        input  cfg_rdata, INT_irq, INT_fiq, irq_id, fiq_id
    );

    modport slave (
        input  src_req, cfg_we, cfg_addr, cfg_wdata, INTA_irq, INTA_fiq,
        output cfg_rdata, INT_irq, INT_fiq, irq_id, fiq_id
    );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding a CPU's IRQ and FIQ request lines.
// Latches NUM_SRC device requests, masks them, routes each to IRQ or FIQ,
// presents the lowest pending index per line and retires it on acknowledge.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   bus (slave)     src_req       device requests (asynchronous to clk)
//                   cfg_we/addr/wdata  config write: 0=MASK 1=FIQ_SEL
//                                 2=SET (write-1-to-set) 3=CLR (write-1-to-clear)
//                   cfg_rdata     combinational readback: 0=mask 1=fiq_sel
//                                 2=pending 3=pending&mask
//                   INTA_irq/fiq  acknowledge pulses from the CPU
//                   INT_irq/fiq   registered request lines
//                   irq_id/fiq_id registered id of the last acknowledged source
//
// Build option: macro INT_EDGE_EN selects edge-triggered hardware requests
// (pending set on a synchronised rising edge, held until ack/CLR). With the
// macro undefined, requests are level-sensitive: pending = sync2 | sw_pend.
module int_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    int_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_FSEL = 2'd1;
    localparam logic [1:0] A_SET  = 2'd2;
    localparam logic [1:0] A_CLR  = 2'd3;

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] fiq_sel_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] irq_vec;
    logic [NUM_SRC-1:0] fiq_vec;
    logic               irq_any;
    logic               fiq_any;
    logic [ID_W-1:0]    win_irq;
    logic [ID_W-1:0]    win_fiq;
    logic [1:0]         irq_st;
    logic [1:0]         irq_nxt;
    logic [1:0]         fiq_st;
    logic [1:0]         fiq_nxt;
    logic               irq_ack;
    logic               fiq_ack;
    logic [NUM_SRC-1:0] set_v;
    logic [NUM_SRC-1:0] clr_v;
    logic               int_irq_q;
    logic               int_fiq_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [ID_W-1:0]    fiq_id_q;
    logic [NUM_SRC-1:0] rdata_c;

`ifdef INT_EDGE_EN
    logic [NUM_SRC-1:0] sync3;
    logic [NUM_SRC-1:0] pend_q;
`else
    logic [NUM_SRC-1:0] sw_pend_q;
`endif

    // Lowest set index wins; returns 0 for an empty vector (never used then).
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [ID_W-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (v[i] && !found) begin
                r     = ID_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Two-stage request synchroniser (plus edge-detect stage in edge mode).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
`ifdef INT_EDGE_EN
            sync3 <= '0;
`endif
        end else begin
            sync1 <= bus.src_req;
            sync2 <= sync1;
`ifdef INT_EDGE_EN
            sync3 <= sync2;
`endif
        end
    end

    // Mask and line-routing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            fiq_sel_q <= '0;
        end else if (bus.cfg_we) begin
            if (bus.cfg_addr == A_MASK) mask_q    <= bus.cfg_wdata;
            if (bus.cfg_addr == A_FSEL) fiq_sel_q <= bus.cfg_wdata;
        end
    end

    // Set/clear sources for the pending state; set beats clear on the same bit.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (bus.cfg_we && (bus.cfg_addr == A_SET)) set_v = bus.cfg_wdata;
        if (bus.cfg_we && (bus.cfg_addr == A_CLR)) clr_v = bus.cfg_wdata;
        if (irq_ack) clr_v = clr_v | (NUM_SRC'(1) << win_irq);
        if (fiq_ack) clr_v = clr_v | (NUM_SRC'(1) << win_fiq);
`ifdef INT_EDGE_EN
        set_v = set_v | (sync2 & ~sync3);
`endif
    end

`ifdef INT_EDGE_EN
    // Edge mode: a latched rising edge stays pending until ack or CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= (pend_q & ~clr_v) | set_v;
    end

    assign pending = pend_q;
`else
    // Level mode: only the software part is stored; a live source re-requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_pend_q <= '0;
        else        sw_pend_q <= (sw_pend_q & ~clr_v) | set_v;
    end

    assign pending = sync2 | sw_pend_q;
`endif

    assign irq_vec = pending & mask_q & ~fiq_sel_q;
    assign fiq_vec = pending & mask_q &  fiq_sel_q;
    assign irq_any = |irq_vec;
    assign fiq_any = |fiq_vec;
    assign win_irq = lowest_idx(irq_vec);
    assign win_fiq = lowest_idx(fiq_vec);

    // Per-line FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_st <= ST_IDLE;
            fiq_st <= ST_IDLE;
        end else begin
            irq_st <= irq_nxt;
            fiq_st <= fiq_nxt;
        end
    end

    // Next state and ack strobes; an ack only counts in REQ with a live winner.
    always_comb begin
        irq_nxt = irq_st;
        fiq_nxt = fiq_st;
        irq_ack = 1'b0;
        fiq_ack = 1'b0;

        case (irq_st)
            ST_IDLE: if (irq_any) irq_nxt = ST_REQ;
            ST_REQ: begin
                if (!irq_any) begin
                    irq_nxt = ST_IDLE;
                end else if (bus.INTA_irq) begin
                    irq_ack = 1'b1;
                    irq_nxt = ST_GAP;
                end
            end
            ST_GAP:  irq_nxt = ST_IDLE;
            default: irq_nxt = ST_IDLE;
        endcase

        case (fiq_st)
            ST_IDLE: if (fiq_any) fiq_nxt = ST_REQ;
            ST_REQ: begin
                if (!fiq_any) begin
                    fiq_nxt = ST_IDLE;
                end else if (bus.INTA_fiq) begin
                    fiq_ack = 1'b1;
                    fiq_nxt = ST_GAP;
                end
            end
            ST_GAP:  fiq_nxt = ST_IDLE;
            default: fiq_nxt = ST_IDLE;
        endcase
    end

    // Registered request lines and captured vector ids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_irq_q <= 1'b0;
            int_fiq_q <= 1'b0;
            irq_id_q  <= '0;
            fiq_id_q  <= '0;
        end else begin
            int_irq_q <= (irq_st == ST_REQ) && irq_any && !irq_ack;
            int_fiq_q <= (fiq_st == ST_REQ) && fiq_any && !fiq_ack;
            if (irq_ack) irq_id_q <= win_irq;
            if (fiq_ack) fiq_id_q <= win_fiq;
        end
    end

    // Combinational config readback.
    always_comb begin
        rdata_c = '0;
        case (bus.cfg_addr)
            A_MASK:  rdata_c = mask_q;
            A_FSEL:  rdata_c = fiq_sel_q;
            A_SET:   rdata_c = pending;
            default: rdata_c = pending & mask_q;
        endcase
    end

    assign bus.cfg_rdata = rdata_c;
    assign bus.INT_irq   = int_irq_q;
    assign bus.INT_fiq   = int_fiq_q;
    assign bus.irq_id    = irq_id_q;
    assign bus.fiq_id    = fiq_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed bench for int_ctrl (works in level and edge builds).
module tb_int_ctrl;

    logic clk;
    logic rst_n;

    int_ctrl_if #(.NUM_SRC(8), .ID_W(3)) ifc ();

    int_ctrl #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (exp_q.size() == 0) ? 32'hDEAD_BEEF : exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        ifc.cfg_we    = 1'b1;
        ifc.cfg_addr  = a;
        ifc.cfg_wdata = d;
        tick();
        ifc.cfg_we    = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a, input logic [7:0] e);
        push(32'(e));
        ifc.cfg_addr = a;
        #1;
        check(tag, 32'(ifc.cfg_rdata));
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        push(32'd1);
        while (ifc.INT_irq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(ifc.INT_irq));
    endtask

    task automatic ack_irq(input logic [7:0] src_after);
        ifc.INTA_irq = 1'b1;
        ifc.src_req  = src_after;
        tick();
        ifc.INTA_irq = 1'b0;
    endtask

    task automatic quiet_irq(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        push(32'd0);
        repeat (cycles) begin
            tick();
            if (ifc.INT_irq !== 1'b0) seen = 1'b1;
        end
        check(tag, 32'(seen));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   rises;
        int   exp_rises;
        logic prev;
        logic acked;
        logic seen;

        rst_n         = 1'b0;
        ifc.src_req   = '0;
        ifc.cfg_we    = 1'b0;
        ifc.cfg_addr  = '0;
        ifc.cfg_wdata = '0;
        ifc.INTA_irq  = 1'b0;
        ifc.INTA_fiq  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state
        push(32'd0); check("rst_int_irq", 32'(ifc.INT_irq));
        push(32'd0); check("rst_int_fiq", 32'(ifc.INT_fiq));
        push(32'd0); check("rst_irq_id",  32'(ifc.irq_id));
        push(32'd0); check("rst_fiq_id",  32'(ifc.fiq_id));
        check_rd("rst_mask", 2'd0, 8'h00);
        check_rd("rst_pending", 2'd2, 8'h00);

        // 1: all sources requesting while fully masked
        ifc.src_req = 8'hFF;
        seen = 1'b0;
        push(32'd0);
        repeat (20) begin
            tick();
            if (ifc.INT_irq !== 1'b0 || ifc.INT_fiq !== 1'b0) seen = 1'b1;
        end
        check("t1_masked_quiet", 32'(seen));
        ifc.src_req = 8'h00;
        repeat (5) tick();
        cfg_write(2'd3, 8'hFF);
        check_rd("t1_pending_cleared", 2'd2, 8'h00);

        // 2: two IRQ sources, serviced lowest index first
        cfg_write(2'd0, 8'hFF);
        cfg_write(2'd1, 8'h00);
        ifc.src_req = 8'h24;
        wait_irq("t2_irq_up");
        push(32'd0); check("t2_fiq_quiet", 32'(ifc.INT_fiq));
        push(32'd2);
        ack_irq(8'h20);
        check("t2_id_first", 32'(ifc.irq_id));
        push(32'd0); check("t2_gap_low", 32'(ifc.INT_irq));
        wait_irq("t2_irq_again");
        push(32'd5);
        ack_irq(8'h00);
        check("t2_id_second", 32'(ifc.irq_id));
        quiet_irq("t2_stays_low", 10);

        // 3: one source per line, acknowledged in the same cycle
        cfg_write(2'd1, 8'h10);
        ifc.src_req = 8'h12;
        n = 0;
        while (!(ifc.INT_irq === 1'b1 && ifc.INT_fiq === 1'b1) && n < 20) begin
            tick();
            n++;
        end
        push(32'd1); check("t3_fiq_up", 32'(ifc.INT_fiq));
        push(32'd1); check("t3_irq_up", 32'(ifc.INT_irq));
        push(32'd4);
        push(32'd1);
        ifc.INTA_irq = 1'b1;
        ifc.INTA_fiq = 1'b1;
        ifc.src_req  = 8'h00;
        tick();
        ifc.INTA_irq = 1'b0;
        ifc.INTA_fiq = 1'b0;
        check("t3_fiq_id", 32'(ifc.fiq_id));
        check("t3_irq_id", 32'(ifc.irq_id));
        push(32'd0); check("t3_irq_low", 32'(ifc.INT_irq));
        push(32'd0); check("t3_fiq_low", 32'(ifc.INT_fiq));
        seen = 1'b0;
        push(32'd0);
        repeat (8) begin
            tick();
            if (ifc.INT_irq !== 1'b0 || ifc.INT_fiq !== 1'b0) seen = 1'b1;
        end
        check("t3_both_stay_low", 32'(seen));

        // 4: software SET then CLR withdraws the request without an ack
        cfg_write(2'd1, 8'h00);
        cfg_write(2'd2, 8'h80);
        check_rd("t4_pending_set", 2'd2, 8'h80);
        wait_irq("t4_irq_up");
        cfg_write(2'd3, 8'h80);
        tick();
        push(32'd0); check("t4_irq_withdrawn", 32'(ifc.INT_irq));
        check_rd("t4_pending_clr", 2'd2, 8'h00);
        push(32'd1); check("t4_id_unchanged", 32'(ifc.irq_id));

        // 5: source held high, acknowledged once
`ifdef INT_EDGE_EN
        exp_rises = 1;
`else
        exp_rises = 2;
`endif
        ifc.src_req = 8'h08;
        rises = 0;
        prev  = 1'b0;
        acked = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ifc.INT_irq === 1'b1 && !prev) rises++;
            prev = ifc.INT_irq;
            if (ifc.INT_irq === 1'b1 && !acked) begin
                ifc.INTA_irq = 1'b1;
                acked = 1'b1;
                push(32'd3);
            end else begin
                ifc.INTA_irq = 1'b0;
            end
            tick();
        end
        ifc.INTA_irq = 1'b0;
        if (!acked) push(32'd3);
        check("t5_id", 32'(ifc.irq_id));
        push(32'(exp_rises)); check("t5_rises", 32'(rises));
        ifc.src_req = 8'h00;
        repeat (6) tick();
        push(32'd0); check("t5_idle_after_release", 32'(ifc.INT_irq));

        // 6: asynchronous reset while a request is outstanding
        cfg_write(2'd2, 8'h0C);
        wait_irq("t6_irq_up");
        #2;
        rst_n = 1'b0;
        #1;
        push(32'd0); check("t6_async_int_irq", 32'(ifc.INT_irq));
        check_rd("t6_async_pending", 2'd2, 8'h00);
        check_rd("t6_async_mask", 2'd0, 8'h00);
        push(32'd0); check("t6_async_irq_id", 32'(ifc.irq_id));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        cfg_write(2'd0, 8'hFF);
        quiet_irq("t6_no_stale_req", 10);
        check_rd("t6_pending_after", 2'd2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
